// File: rtl/hs_arith_seq_umin_arbiter.sv
// Sequential minimum-priority arbiter: snapshots the request vector, scans one
// requester per cycle through a single two-input unsigned minimize stage, then grants.
module hs_arith_seq_umin_arbiter #(
  parameter int NUM_REQ    = 8,
  parameter int DATA_WIDTH = 32,
  localparam int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] prio,
  output logic                          busy,
  output logic                          gnt_valid,
  input  logic                          gnt_ready,
  output logic [IDX_WIDTH-1:0]          gnt_index,
  output logic [DATA_WIDTH-1:0]         gnt_value
);

  typedef enum logic [1:0] {IDLE, SCAN, GRANT} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

  state_t                state;
  logic [NUM_REQ-1:0]    req_snap;
  logic [DATA_WIDTH-1:0] prio_snap [NUM_REQ];
  logic [IDX_WIDTH-1:0]  scan_idx;
  logic                  acc_valid;
  logic [DATA_WIDTH-1:0] acc_val;
  logic [IDX_WIDTH-1:0]  acc_idx;

  logic [DATA_WIDTH-1:0] cur_val;
  logic                  cur_req;
  logic                  din1_wins;

  // Strict less-than keeps the earlier (lower) index on ties.
  always_comb begin
    cur_val   = prio_snap[scan_idx];
    cur_req   = req_snap[scan_idx];
    din1_wins = cur_req && (!acc_valid || (cur_val < acc_val));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_snap  <= '0;
      for (int i = 0; i < NUM_REQ; i++) prio_snap[i] <= '0;
      scan_idx  <= '0;
      acc_valid <= 1'b0;
      acc_val   <= '0;
      acc_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt_index <= '0;
      gnt_value <= '0;
    end else if (flush) begin
      state     <= IDLE;
      req_snap  <= '0;
      scan_idx  <= '0;
      acc_valid <= 1'b0;
      acc_val   <= '0;
      acc_idx   <= '0;
      gnt_valid <= 1'b0;
      gnt_index <= '0;
      gnt_value <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            req_snap <= req;
            for (int i = 0; i < NUM_REQ; i++) prio_snap[i] <= prio[i*DATA_WIDTH +: DATA_WIDTH];
            acc_valid <= 1'b0;
            acc_val   <= '0;
            acc_idx   <= '0;
            scan_idx  <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (din1_wins) begin
            acc_val <= cur_val;
            acc_idx <= scan_idx;
          end
          acc_valid <= acc_valid | cur_req;
          if (scan_idx == LAST_IDX) state <= GRANT;
          else                      scan_idx <= scan_idx + 1'b1;
        end
        GRANT: begin
          // First GRANT cycle registers the result; ready only matters once it is visible.
          if (!gnt_valid) begin
            gnt_valid <= 1'b1;
            gnt_index <= acc_idx;
            gnt_value <= acc_val;
          end else if (gnt_ready) begin
            gnt_valid <= 1'b0;
            gnt_index <= '0;
            gnt_value <= '0;
            scan_idx  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_arith_seq_umin_arbiter.sv
// Self-checking bench: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_hs_arith_seq_umin_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] prio = '0;
  logic            gnt_ready = 1'b0;
  logic            busy;
  logic            gnt_valid;
  logic [IW-1:0]   gnt_index;
  logic [DW-1:0]   gnt_value;

  hs_arith_seq_umin_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .prio(prio),
    .busy(busy), .gnt_valid(gnt_valid), .gnt_ready(gnt_ready),
    .gnt_index(gnt_index), .gnt_value(gnt_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is a winner chosen at snapshot time plus a
  // cycle count; the grant appears NUM_REQ+1 edges after the snapshot.
  logic          m_busy = 1'b0;
  logic          m_gv   = 1'b0;
  int            m_cnt  = 0;
  logic [IW-1:0] m_idx  = '0;
  logic [DW-1:0] m_val  = '0;

  function automatic void pick(input logic [N-1:0] r, input logic [N*DW-1:0] p,
                               output logic [IW-1:0] idx, output logic [DW-1:0] val);
    int best;
    best = 256;
    for (int i = 0; i < N; i++)
      if (r[i] && int'(p[i*DW +: DW]) < best) best = int'(p[i*DW +: DW]);
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (r[i] && int'(p[i*DW +: DW]) == best) idx = IW'(i);
    val = DW'(best);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_gv = 1'b0; m_cnt = 0; m_idx = '0; m_val = '0;
    end else if (flush) begin
      m_busy = 1'b0; m_gv = 1'b0;
    end else if (!m_busy) begin
      if (|req) begin
        pick(req, prio, m_idx, m_val);
        m_busy = 1'b1; m_cnt = 0;
      end
    end else if (!m_gv) begin
      m_cnt++;
      if (m_cnt == N + 1) m_gv = 1'b1;
    end else if (gnt_ready) begin
      m_busy = 1'b0; m_gv = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(m_busy));
    chk("gnt_valid", 64'(gnt_valid), 64'(m_gv));
    chk("gnt_index", 64'(gnt_index), m_gv ? 64'(m_idx) : 64'd0);
    chk("gnt_value", 64'(gnt_value), m_gv ? 64'(m_val) : 64'd0);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Counts edges after the snapshot edge until gnt_valid is seen.
  task automatic wait_grant(input string name, output int cyc);
    cyc = 0;
    while (!gnt_valid && cyc < 30) begin
      step();
      cyc++;
    end
    if (!gnt_valid) begin
      fails++;
      $display("FAIL %s: timeout waiting for gnt_valid", name);
    end
  endtask

  task automatic directed(input string name, input logic [N-1:0] r, input logic [N*DW-1:0] p,
                          input logic [IW-1:0] e_idx, input logic [DW-1:0] e_val);
    int cyc;
    req = r; prio = p; gnt_ready = 1'b1;
    step();
    req = '0; prio = '0;
    wait_grant(name, cyc);
    chk({name, "_latency"}, 64'(cyc), 64'(N + 1));
    chk({name, "_index"}, 64'(gnt_index), 64'(e_idx));
    chk({name, "_value"}, 64'(gnt_value), 64'(e_val));
    step();
    chk({name, "_idle_after"}, 64'({busy, gnt_valid}), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [IW-1:0] s_idx;
    logic [DW-1:0] s_val;
    #2;
    chk("reset_outputs", 64'({busy, gnt_valid, gnt_index, gnt_value}), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    directed("a", 4'b1111, {8'h20, 8'h05, 8'h40, 8'h10}, 2'd2, 8'h05);
    directed("b", 4'b1010, {8'h07, 8'h07, 8'h07, 8'h07}, 2'd1, 8'h07);
    directed("c", 4'b1000, {8'hFF, 8'h00, 8'h00, 8'h00}, 2'd3, 8'hFF);

    // (d) inputs change after the snapshot; hold ready low
    req = 4'b0011; prio = {8'h30, 8'h30, 8'h09, 8'h0A}; gnt_ready = 1'b0;
    step();
    prio[7:0] = 8'h00; req = '0;
    wait_grant("d", cyc);
    chk("d_latency", 64'(cyc), 64'(N + 1));
    chk("d_index", 64'(gnt_index), 64'd1);
    chk("d_value", 64'(gnt_value), 64'h09);
    s_idx = gnt_index; s_val = gnt_value;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("d_hold", 64'({busy, gnt_valid, gnt_index, gnt_value}), 64'({2'b11, s_idx, s_val}));
    end
    gnt_ready = 1'b1;
    step();
    chk("d_release", 64'({busy, gnt_valid}), 64'd0);

    // (e) flush during scan, then immediate re-snapshot
    req = 4'b1111; prio = {8'h33, 8'h22, 8'h11, 8'h44};
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("e_flush_idle", 64'({busy, gnt_valid}), 64'd0);
    step();
    chk("e_resnap_busy", 64'(busy), 64'd1);
    req = '0;
    wait_grant("e", cyc);
    chk("e_latency", 64'(cyc), 64'(N + 1));
    chk("e_index", 64'(gnt_index), 64'd1);
    step();

    // (f) asynchronous reset in GRANT
    req = 4'b0100; prio = {8'h00, 8'h66, 8'h00, 8'h00}; gnt_ready = 1'b0;
    step();
    req = '0;
    wait_grant("f", cyc);
    chk("f_pre_value", 64'(gnt_value), 64'h66);
    #2 rst_n = 1'b0;
    #1 chk("f_async_reset", 64'({busy, gnt_valid, gnt_index, gnt_value}), 64'd0);
    step();
    req = 4'b0001;
    step();
    chk("f_no_snap_in_reset", 64'(busy), 64'd0);
    rst_n = 1'b1;
    req = '0;
    step();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req       = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      prio      = {$urandom};
      if ($urandom_range(0, 3) == 0) prio[DW-1:0] = prio[2*DW-1:DW];
      gnt_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      step();
    end
    flush = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
